// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS pipeline stages.
//   NOP_INSTR        - encoding loaded into IF/ID when a bubble is inserted
//   PC_INC           - byte distance between sequential instructions
//   RESET_PC_DEFAULT - default fetch address after reset
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          PC_INC           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/pipe_reg.sv
// pipe_reg: parameterised-width pipeline register.
//   clk, rst_n - clock, asynchronous active-low reset (loads RST_VAL)
//   en         - synchronous load enable for d
//   clr        - synchronous clear to CLR_VAL; takes priority over en
//   d, q       - data in / registered data out
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // clr wins over en so that a squash still lands while the stage is held
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = CLR_VAL;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : pipe_reg

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Holds the PC, forms PC+4, picks the next PC (jump > branch > stall-hold >
// sequential) and registers the fetched instruction into IF/ID.
//   clk, rst_n         - clock, asynchronous active-low reset
//   stall              - hold PC and IF/ID
//   flush              - load a bubble into IF/ID
//   pcsrc, pcbranch    - taken branch and its target
//   jump, jumpaddr     - jump and its fully formed target
//   instr_in           - instruction memory data for address pc
//   pc                 - current fetch address
//   pcplus_d, instr_d,
//   valid_d            - IF/ID register outputs (valid_d=0 marks a bubble)
module fetch_stage
    import mips_pkg::*;
#(
    parameter int            size     = 31,
    parameter logic [size:0] RESET_PC = (size+1)'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          pcsrc,
    input  logic [size:0] pcbranch,
    input  logic          jump,
    input  logic [size:0] jumpaddr,
    input  logic [31:0]   instr_in,
    output logic [size:0] pc,
    output logic [size:0] pcplus_d,
    output logic [31:0]   instr_d,
    output logic          valid_d
);

    logic [size:0] pcplus;
    logic [size:0] pc_next;
    logic          redirect;
    logic          ifid_clr;
    logic          ifid_en;

    // Wraps modulo 2^(size+1); all-ones minus 3 rolls over to zero.
    assign pcplus   = pc + (size+1)'(PC_INC);
    assign redirect = jump | pcsrc;

    // A redirect overrides stall: the target must be fetched next cycle.
    always_comb begin
        pc_next = pcplus;
        if (jump) begin
            pc_next = jumpaddr;
        end else if (pcsrc) begin
            pc_next = pcbranch;
        end else if (stall) begin
            pc_next = pc;
        end
    end

    // The instruction fetched alongside a redirect is on the wrong path, so
    // it is squashed; a flush during a stall also bubbles rather than holds.
    assign ifid_clr = flush | redirect;
    assign ifid_en  = ~stall;

    pipe_reg #(
        .W       (size+1),
        .RST_VAL (RESET_PC),
        .CLR_VAL ('0)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (pc_next),
        .q     (pc)
    );

    pipe_reg #(
        .W       (size+1),
        .RST_VAL ('0),
        .CLR_VAL ('0)
    ) u_pcplus_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ifid_en),
        .clr   (ifid_clr),
        .d     (pcplus),
        .q     (pcplus_d)
    );

    pipe_reg #(
        .W       (32),
        .RST_VAL (NOP_INSTR),
        .CLR_VAL (NOP_INSTR)
    ) u_instr_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ifid_en),
        .clr   (ifid_clr),
        .d     (instr_in),
        .q     (instr_d)
    );

    pipe_reg #(
        .W       (1),
        .RST_VAL (1'b0),
        .CLR_VAL (1'b0)
    ) u_valid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ifid_en),
        .clr   (ifid_clr),
        .d     (1'b1),
        .q     (valid_d)
    );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. Instruction memory returns
// 32'h2008_0005 at address 0 and (32'hC000_0000 | addr) elsewhere.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        pcsrc;
    logic [31:0] pcbranch;
    logic        jump;
    logic [31:0] jumpaddr;
    logic [31:0] instr_in;
    logic [31:0] pc;
    logic [31:0] pcplus_d;
    logic [31:0] instr_d;
    logic        valid_d;

    int vectors;
    int errors;

    fetch_stage #(.size(31), .RESET_PC(32'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .flush    (flush),
        .pcsrc    (pcsrc),
        .pcbranch (pcbranch),
        .jump     (jump),
        .jumpaddr (jumpaddr),
        .instr_in (instr_in),
        .pc       (pc),
        .pcplus_d (pcplus_d),
        .instr_d  (instr_d),
        .valid_d  (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr_in = (pc == 32'h0) ? 32'h2008_0005 : (32'hC000_0000 | pc);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; flush = 0; pcsrc = 0; jump = 0;
        pcbranch = 0; jumpaddr = 0;
        #12;
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", pc, 32'h0); end
        vectors++; if (pcplus_d !== 32'h0) begin errors++; $display("FAIL rst_pcplus got %h exp %h", pcplus_d, 32'h0); end
        vectors++; if (instr_d !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp %h", instr_d, 32'h0); end
        vectors++; if (valid_d !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_d); end
        rst_n = 1'b1;
        step();
        vectors++; if (pc !== 32'h4) begin errors++; $display("FAIL rel_pc got %h exp %h", pc, 32'h4); end
        vectors++; if (instr_d !== 32'h2008_0005) begin errors++; $display("FAIL rel_instr got %h exp %h", instr_d, 32'h2008_0005); end
        vectors++; if (pcplus_d !== 32'h4) begin errors++; $display("FAIL rel_pcplus got %h exp %h", pcplus_d, 32'h4); end
        vectors++; if (valid_d !== 1'b1) begin errors++; $display("FAIL rel_valid got %b exp 1", valid_d); end
        step();
        vectors++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, 32'h8); end
        vectors++; if (instr_d !== 32'hC000_0004) begin errors++; $display("FAIL seq_instr got %h exp %h", instr_d, 32'hC000_0004); end
        vectors++; if (pcplus_d !== 32'h8) begin errors++; $display("FAIL seq_pcplus got %h exp %h", pcplus_d, 32'h8); end
    endtask

    task automatic test_branch();
        pcsrc = 1'b1; pcbranch = 32'h40;
        step();
        pcsrc = 1'b0;
        vectors++; if (pc !== 32'h40) begin errors++; $display("FAIL br_pc got %h exp %h", pc, 32'h40); end
        vectors++; if (valid_d !== 1'b0) begin errors++; $display("FAIL br_valid got %b exp 0", valid_d); end
        vectors++; if (instr_d !== 32'h0) begin errors++; $display("FAIL br_instr got %h exp %h", instr_d, 32'h0); end
        vectors++; if (pcplus_d !== 32'h0) begin errors++; $display("FAIL br_pcplus got %h exp %h", pcplus_d, 32'h0); end
        step();
        vectors++; if (instr_d !== 32'hC000_0040) begin errors++; $display("FAIL br_tgt_instr got %h exp %h", instr_d, 32'hC000_0040); end
        vectors++; if (pcplus_d !== 32'h44) begin errors++; $display("FAIL br_tgt_pcplus got %h exp %h", pcplus_d, 32'h44); end
        vectors++; if (valid_d !== 1'b1) begin errors++; $display("FAIL br_tgt_valid got %b exp 1", valid_d); end
        vectors++; if (pc !== 32'h44) begin errors++; $display("FAIL br_tgt_pc got %h exp %h", pc, 32'h44); end
    endtask

    task automatic test_stall();
        // asynchronous reset pulse between edges, then run up to pc=12
        #2; rst_n = 1'b0; #1;
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL rst2_pc got %h exp %h", pc, 32'h0); end
        rst_n = 1'b1;
        step(); step(); step();
        vectors++; if (pc !== 32'hC) begin errors++; $display("FAIL st_pre_pc got %h exp %h", pc, 32'hC); end
        vectors++; if (instr_d !== 32'hC000_0008) begin errors++; $display("FAIL st_pre_instr got %h exp %h", instr_d, 32'hC000_0008); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (pc !== 32'hC) begin errors++; $display("FAIL st_pc[%0d] got %h exp %h", i, pc, 32'hC); end
            vectors++; if (instr_d !== 32'hC000_0008) begin errors++; $display("FAIL st_instr[%0d] got %h exp %h", i, instr_d, 32'hC000_0008); end
            vectors++; if (pcplus_d !== 32'hC) begin errors++; $display("FAIL st_pcplus[%0d] got %h exp %h", i, pcplus_d, 32'hC); end
        end
        stall = 1'b0;
        step();
        vectors++; if (pc !== 32'h10) begin errors++; $display("FAIL st_rel_pc got %h exp %h", pc, 32'h10); end
        vectors++; if (instr_d !== 32'hC000_000C) begin errors++; $display("FAIL st_rel_instr got %h exp %h", instr_d, 32'hC000_000C); end
        vectors++; if (pcplus_d !== 32'h10) begin errors++; $display("FAIL st_rel_pcplus got %h exp %h", pcplus_d, 32'h10); end
        step();
        vectors++; if (instr_d !== 32'hC000_0010) begin errors++; $display("FAIL st_nodup_instr got %h exp %h", instr_d, 32'hC000_0010); end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; pcsrc = 1'b1; pcbranch = 32'h100;
        step();
        stall = 1'b0; pcsrc = 1'b0;
        vectors++; if (pc !== 32'h100) begin errors++; $display("FAIL sr_pc got %h exp %h", pc, 32'h100); end
        vectors++; if (valid_d !== 1'b0) begin errors++; $display("FAIL sr_valid got %b exp 0", valid_d); end
        step();
        vectors++; if (instr_d !== 32'hC000_0100) begin errors++; $display("FAIL sr_tgt_instr got %h exp %h", instr_d, 32'hC000_0100); end
    endtask

    task automatic test_jump_priority();
        jump = 1'b1; jumpaddr = 32'h200; pcsrc = 1'b1; pcbranch = 32'h80;
        step();
        jump = 1'b0; pcsrc = 1'b0;
        vectors++; if (pc !== 32'h200) begin errors++; $display("FAIL jp_pc got %h exp %h", pc, 32'h200); end
        vectors++; if (valid_d !== 1'b0) begin errors++; $display("FAIL jp_valid got %b exp 0", valid_d); end
        step();
        vectors++; if (instr_d !== 32'hC000_0200) begin errors++; $display("FAIL jp_tgt_instr got %h exp %h", instr_d, 32'hC000_0200); end
        vectors++; if (pcplus_d !== 32'h204) begin errors++; $display("FAIL jp_tgt_pcplus got %h exp %h", pcplus_d, 32'h204); end
    endtask

    task automatic test_flush_stall();
        // pc is 0x204 here; flush while stalled bubbles IF/ID, PC holds
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        vectors++; if (pc !== 32'h204) begin errors++; $display("FAIL fs_pc got %h exp %h", pc, 32'h204); end
        vectors++; if (valid_d !== 1'b0) begin errors++; $display("FAIL fs_valid got %b exp 0", valid_d); end
        vectors++; if (instr_d !== 32'h0) begin errors++; $display("FAIL fs_instr got %h exp %h", instr_d, 32'h0); end
    endtask

    task automatic test_wrap_and_async_reset();
        jump = 1'b1; jumpaddr = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        vectors++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pc got %h exp %h", pc, 32'hFFFF_FFFC); end
        step();
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL wr_next_pc got %h exp %h", pc, 32'h0); end
        vectors++; if (pcplus_d !== 32'h0) begin errors++; $display("FAIL wr_pcplus got %h exp %h", pcplus_d, 32'h0); end
        vectors++; if (instr_d !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_instr got %h exp %h", instr_d, 32'hFFFF_FFFC); end
        vectors++; if (valid_d !== 1'b1) begin errors++; $display("FAIL wr_valid got %b exp 1", valid_d); end
        step();
        vectors++; if (pc !== 32'h4) begin errors++; $display("FAIL wr2_pc got %h exp %h", pc, 32'h4); end
        // pending branch at reset time must be discarded
        pcsrc = 1'b1; pcbranch = 32'h300;
        #2; rst_n = 1'b0; #1;
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL ar_pc got %h exp %h", pc, 32'h0); end
        vectors++; if (pcplus_d !== 32'h0) begin errors++; $display("FAIL ar_pcplus got %h exp %h", pcplus_d, 32'h0); end
        vectors++; if (instr_d !== 32'h0) begin errors++; $display("FAIL ar_instr got %h exp %h", instr_d, 32'h0); end
        vectors++; if (valid_d !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", valid_d); end
        pcsrc = 1'b0;
        step();
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL ar_hold_pc got %h exp %h", pc, 32'h0); end
        rst_n = 1'b1;
        step();
        vectors++; if (pc !== 32'h4) begin errors++; $display("FAIL ar_rel_pc got %h exp %h", pc, 32'h4); end
        vectors++; if (instr_d !== 32'h2008_0005) begin errors++; $display("FAIL ar_rel_instr got %h exp %h", instr_d, 32'h2008_0005); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_branch();
        test_stall();
        test_stall_redirect();
        test_jump_priority();
        test_flush_stall();
        test_wrap_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: holds the program counter, computes PC+4, selects the next PC from sequential, branch-target or jump sources, and registers the fetched instruction with its PC+4 into the IF/ID pipeline register. Its registered `pcplus_d` is the value the decode/execute path feeds into the branch-target adder. The resulting `pcbranch` target returns here as the redirect address.

## Interface

Parameters:
- `size`, default 31: MSB index of the address datapath (width = size+1).
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard-unit stall: hold PC and IF/ID contents.
- `flush`  in  1  hazard-unit flush: load a bubble into IF/ID.
- `pcsrc`  in  1  branch taken: next PC = `pcbranch`.
- `pcbranch`  in  size+1  branch target from the branch-target adder.
- `jump`  in  1  jump: next PC = `jumpaddr`.
- `jumpaddr`  in  size+1  jump target, fully formed by decode.
- `instr_in`  in  32  instruction memory read data for address `pc`, combinational.
- `pc`  out  size+1  current fetch address to instruction memory.
- `pcplus_d`  out  size+1  IF/ID: PC+4 of the instruction in `instr_d`.
- `instr_d`  out  32  IF/ID: fetched instruction.
- `valid_d`  out  1  IF/ID: 1 = real instruction, 0 = bubble.

## Operation

- `pcplus = pc + 4`. Modulo 2^(size+1) and wraps silently: all-ones minus 3 goes to 0. Combinational, internal only.
- Next-PC priority, highest first: `jump` → `jumpaddr`; `pcsrc` → `pcbranch`; `stall` → hold `pc`; else `pcplus`.
- A redirect (`jump` or `pcsrc`) overrides `stall` for the PC.
- `jump` and `pcsrc` both high: `jump` wins.
- IF/ID priority, highest first:
  - `flush`, `jump` or `pcsrc`: bubble, i.e. `instr_d`=0 (NOP), `pcplus_d`=0, `valid_d`=0.
  - `stall`: hold all three.
  - Otherwise: `instr_d`←`instr_in`, `pcplus_d`←`pcplus`, `valid_d`←1.
- A redirect squashes the wrong-path instruction being fetched in the same cycle. A flush during a stall produces a bubble and does not hold.
- Redirect targets are used unchanged: no alignment check, and low two bits pass through.
- No state machine beyond the PC and IF/ID registers. The block is two enabled registers with priority muxes.

## Timing

- Reset (`rst_n`=0, asynchronous, immediate): `pc`=RESET_PC, `pcplus_d`=0, `instr_d`=0, `valid_d`=0.
- After `rst_n` rises, the first edge latches `instr_in` for RESET_PC, so `valid_d`=1 and `pcplus_d`=RESET_PC+4.
- Fetch latency: the instruction at `pc` in cycle N appears on `instr_d` in cycle N+1.
- Redirect sampled at edge N: `pc` = target in cycle N+1, and the target's instruction appears on `instr_d` in cycle N+2. Exactly one bubble is inserted in cycle N+1.
- Stall held for k cycles: `pc` and IF/ID are frozen for k cycles with no instruction lost or duplicated.
- Reset asserted mid-stall or mid-redirect: reset wins immediately. Pending redirects are discarded.

## Structure

- Shared package (`mips_pkg`): `NOP_INSTR` = 32'h0000_0000, `PC_INC` = 4, `RESET_PC` default.
- One sub-module, `pipe_reg`: parameterised-width register with async active-low reset to a reset value, synchronous `en`, and synchronous `clr`. Instantiate it for the PC (`clr` tied 0) and for each IF/ID field.
- The next-PC mux and PC+4 adder stay in `fetch_stage`.

## Test plan

- Reset release, `instr_in`=32'h2008_0005: after edge 1 `pc`=4, `instr_d`=32'h2008_0005, `pcplus_d`=4, `valid_d`=1.
- `pc`=8, `pcsrc`=1, `pcbranch`=32'h40: next cycle `pc`=32'h40 and `valid_d`=0, then `instr_d` = the instruction at 0x40 with `pcplus_d`=32'h44.
- `stall`=1 for 3 cycles at `pc`=12: `pc` stays 12 and `instr_d` is unchanged. After release, `pc`=16 with no duplicate fetch.
- `stall`=1 with `pcsrc`=1 and `pcbranch`=32'h100: `pc`→32'h100 and `valid_d`=0.
- `jump`=1 (`jumpaddr`=32'h200) and `pcsrc`=1 (`pcbranch`=32'h80) together: `pc`→32'h200.
- `pc`=32'hFFFF_FFFC sequential: `pc`→0 and `pcplus_d`=0. Then assert `rst_n`=0 mid-cycle: outputs reset immediately with no clock edge.
